// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU operation codes, ctrl-bundle bit positions
// and the operand forward-select encoding.
package mips_pkg;

    localparam logic [3:0] ALU_LUI = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;

    // ctrl bundle layout: {reg_write, mem_read, mem_write, mem_to_reg}
    localparam int CTRL_REG_WRITE  = 3;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MWB = 2'd1,
        FWD_EXM = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/operand_forward_sel.sv
// Per-source operand select: EX/MEM beats MEM/WB beats the registered
// register-file value; register $0 is never bypassed.
module operand_forward_sel
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_exm_en,
    input  logic [REG_AW-1:0] i_exm_reg,
    input  logic [DATA_W-1:0] i_exm_data,
    input  logic              i_mwb_en,
    input  logic [REG_AW-1:0] i_mwb_reg,
    input  logic [DATA_W-1:0] i_mwb_data,
    output logic [DATA_W-1:0] o_data
);

    fwd_sel_t w_sel;

    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        w_sel = FWD_RF;
        if (i_src != '0) begin
            if (i_exm_en && (i_exm_reg == i_src)) begin
                w_sel = FWD_EXM;
            end else if (i_mwb_en && (i_mwb_reg == i_src)) begin
                w_sel = FWD_MWB;
            end
        end
    end

    always_comb begin
        o_data = i_rf_data;
        case (w_sel)
            FWD_EXM: o_data = i_exm_data;
            FWD_MWB: o_data = i_mwb_data;
            default: o_data = i_rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use detection and EX operand selection.
// Define OPERAND_FORWARDING_EN to bypass from EX/MEM and MEM/WB; otherwise every RAW hazard stalls.
module id_ex_operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid_i,
    input  logic [REG_AW-1:0]  id_rs_i,
    input  logic [REG_AW-1:0]  id_rt_i,
    input  logic               id_rt_used_i,
    input  logic [REG_AW-1:0]  id_write_reg_i,
    input  logic [DATA_W-1:0]  id_rs_data_i,
    input  logic [DATA_W-1:0]  id_rt_data_i,
    input  logic [DATA_W-1:0]  id_imm_i,
    input  logic [ALUOP_W-1:0] id_alu_op_i,
    input  logic [4:0]         id_shamt_i,
    input  logic               id_alu_src_i,
    input  logic [3:0]         id_ctrl_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               exm_reg_write_i,
    input  logic [REG_AW-1:0]  exm_write_reg_i,
    input  logic [DATA_W-1:0]  exm_data_i,
    input  logic               mwb_reg_write_i,
    input  logic [REG_AW-1:0]  mwb_write_reg_i,
    input  logic [DATA_W-1:0]  mwb_data_i,
    output logic               hazard_stall_o,
    output logic               ex_valid_o,
    output logic [ALUOP_W-1:0] alu_operation_o,
    output logic [DATA_W-1:0]  alu_a_o,
    output logic [DATA_W-1:0]  alu_b_o,
    output logic [4:0]         alu_shamt_o,
    output logic [DATA_W-1:0]  ex_store_data_o,
    output logic [REG_AW-1:0]  ex_write_reg_o,
    output logic [3:0]         ex_ctrl_o
);

    typedef struct packed {
        logic               valid;
        logic [3:0]         ctrl;
        logic [REG_AW-1:0]  write_reg;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [ALUOP_W-1:0] alu_op;
        logic [4:0]         shamt;
        logic               alu_src;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  imm;
    } stage_t;

    stage_t             r_ex;
    stage_t             w_id;
    logic               w_load_use;
    logic [DATA_W-1:0]  w_rs_fwd;
    logic [DATA_W-1:0]  w_rt_fwd;

    function automatic logic reads_dst(input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rt, input logic rt_used);
        return (dst != '0) && ((dst == rs) || (rt_used && (dst == rt)));
    endfunction

    assign w_load_use = id_valid_i && r_ex.valid && r_ex.ctrl[CTRL_MEM_READ]
                        && reads_dst(r_ex.write_reg, id_rs_i, id_rt_i, id_rt_used_i);

`ifdef OPERAND_FORWARDING_EN
    localparam logic FWD_EN = 1'b1;
    assign hazard_stall_o = w_load_use;
`else
    localparam logic FWD_EN = 1'b0;
    logic w_raw_stall;
    // The register file does not bypass, so any in-flight writer of an ID source must drain first.
    assign w_raw_stall = id_valid_i && (
        (r_ex.valid && r_ex.ctrl[CTRL_REG_WRITE] && reads_dst(r_ex.write_reg, id_rs_i, id_rt_i, id_rt_used_i))
        || (exm_reg_write_i && reads_dst(exm_write_reg_i, id_rs_i, id_rt_i, id_rt_used_i))
        || (mwb_reg_write_i && reads_dst(mwb_write_reg_i, id_rs_i, id_rt_i, id_rt_used_i)));
    assign hazard_stall_o = w_load_use || w_raw_stall;
`endif

    always_comb begin
        w_id           = '0;
        w_id.valid     = id_valid_i;
        w_id.ctrl      = id_ctrl_i;
        w_id.write_reg = id_write_reg_i;
        w_id.rs        = id_rs_i;
        w_id.rt        = id_rt_i;
        w_id.alu_op    = id_alu_op_i;
        w_id.shamt     = id_shamt_i;
        w_id.alu_src   = id_alu_src_i;
        w_id.rs_data   = id_rs_data_i;
        w_id.rt_data   = id_rt_data_i;
        w_id.imm       = id_imm_i;
    end

    // Flush beats stall; a load-use bubble only enters when the pipe is moving.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            r_ex <= '0;
        end else if (flush_i || (!stall_i && hazard_stall_o)) begin
            r_ex <= '0;
        end else if (!stall_i) begin
            r_ex <= w_id;
        end
    end

    operand_forward_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .i_src      (r_ex.rs),
        .i_rf_data  (r_ex.rs_data),
        .i_exm_en   (FWD_EN & exm_reg_write_i),
        .i_exm_reg  (exm_write_reg_i),
        .i_exm_data (exm_data_i),
        .i_mwb_en   (FWD_EN & mwb_reg_write_i),
        .i_mwb_reg  (mwb_write_reg_i),
        .i_mwb_data (mwb_data_i),
        .o_data     (w_rs_fwd)
    );

    operand_forward_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .i_src      (r_ex.rt),
        .i_rf_data  (r_ex.rt_data),
        .i_exm_en   (FWD_EN & exm_reg_write_i),
        .i_exm_reg  (exm_write_reg_i),
        .i_exm_data (exm_data_i),
        .i_mwb_en   (FWD_EN & mwb_reg_write_i),
        .i_mwb_reg  (mwb_write_reg_i),
        .i_mwb_data (mwb_data_i),
        .o_data     (w_rt_fwd)
    );

    assign ex_valid_o      = r_ex.valid;
    assign ex_ctrl_o       = r_ex.ctrl;
    assign ex_write_reg_o  = r_ex.write_reg;
    assign alu_operation_o = r_ex.alu_op;
    assign alu_shamt_o     = r_ex.shamt;
    assign alu_a_o         = w_rs_fwd;
    assign alu_b_o         = r_ex.alu_src ? r_ex.imm : w_rt_fwd;
    assign ex_store_data_o = w_rt_fwd;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized and directed bench for id_ex_operand_stage against a transaction-level model;
// follows OPERAND_FORWARDING_EN the same way the design does.
module tb_id_ex_operand_stage;

`ifdef OPERAND_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid_i, id_rt_used_i, id_alu_src_i, stall_i, flush_i;
    logic [4:0]  id_rs_i, id_rt_i, id_write_reg_i, id_shamt_i;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [3:0]  id_alu_op_i, id_ctrl_i;
    logic        exm_reg_write_i, mwb_reg_write_i;
    logic [4:0]  exm_write_reg_i, mwb_write_reg_i;
    logic [31:0] exm_data_i, mwb_data_i;
    logic        hazard_stall_o, ex_valid_o;
    logic [3:0]  alu_operation_o, ex_ctrl_o;
    logic [31:0] alu_a_o, alu_b_o, ex_store_data_o;
    logic [4:0]  alu_shamt_o, ex_write_reg_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset),
        .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rt_used_i(id_rt_used_i),
        .id_write_reg_i(id_write_reg_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
        .id_imm_i(id_imm_i), .id_alu_op_i(id_alu_op_i), .id_shamt_i(id_shamt_i),
        .id_alu_src_i(id_alu_src_i), .id_ctrl_i(id_ctrl_i), .stall_i(stall_i), .flush_i(flush_i),
        .exm_reg_write_i(exm_reg_write_i), .exm_write_reg_i(exm_write_reg_i), .exm_data_i(exm_data_i),
        .mwb_reg_write_i(mwb_reg_write_i), .mwb_write_reg_i(mwb_write_reg_i), .mwb_data_i(mwb_data_i),
        .hazard_stall_o(hazard_stall_o), .ex_valid_o(ex_valid_o), .alu_operation_o(alu_operation_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_shamt_o(alu_shamt_o),
        .ex_store_data_o(ex_store_data_o), .ex_write_reg_o(ex_write_reg_o), .ex_ctrl_o(ex_ctrl_o)
    );

    // Output bundle order: {valid, ctrl, write_reg, alu_op, shamt, a, b, store}
    typedef logic [114:0] out_t;

    // Model of the instruction currently sitting in EX
    typedef struct packed {
        logic        valid;
        logic [3:0]  ctrl;
        logic [4:0]  wr, rs, rt;
        logic [3:0]  op;
        logic [4:0]  sh;
        logic        src;
        logic [31:0] rs_d, rt_d, imm;
    } ex_t;

    ex_t m;

    function automatic out_t observed();
        return {ex_valid_o, ex_ctrl_o, ex_write_reg_o, alu_operation_o, alu_shamt_o,
                alu_a_o, alu_b_o, ex_store_data_o};
    endfunction

    function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] rf);
        if (FWD && r != 5'd0 && exm_reg_write_i && exm_write_reg_i == r) return exm_data_i;
        if (FWD && r != 5'd0 && mwb_reg_write_i && mwb_write_reg_i == r) return mwb_data_i;
        return rf;
    endfunction

    function automatic out_t exp_out();
        logic [31:0] a, st, b;
        a  = resolve(m.rs, m.rs_d);
        st = resolve(m.rt, m.rt_d);
        b  = m.src ? m.imm : st;
        return {m.valid, m.ctrl, m.wr, m.op, m.sh, a, b, st};
    endfunction

    // Producers that force ID to wait: a load in EX always; without bypass, any pending writer.
    function automatic logic exp_hazard();
        logic [4:0] dst [3];
        logic       act [3];
        logic       h;
        dst[0] = m.wr;            act[0] = m.valid && (m.ctrl[2] || (!FWD && m.ctrl[3]));
        dst[1] = exm_write_reg_i; act[1] = !FWD && exm_reg_write_i;
        dst[2] = mwb_write_reg_i; act[2] = !FWD && mwb_reg_write_i;
        h = 1'b0;
        for (int p = 0; p < 3; p++)
            if (act[p] && dst[p] != 5'd0 && (dst[p] == id_rs_i || (id_rt_used_i && dst[p] == id_rt_i)))
                h = 1'b1;
        return id_valid_i && h;
    endfunction

    task automatic model_edge(input logic hz);
        if (flush_i)       m = '0;
        else if (stall_i)  m = m;
        else if (hz)       m = '0;
        else begin
            m.valid = id_valid_i;   m.ctrl = id_ctrl_i;      m.wr = id_write_reg_i;
            m.rs    = id_rs_i;      m.rt   = id_rt_i;        m.op = id_alu_op_i;
            m.sh    = id_shamt_i;   m.src  = id_alu_src_i;   m.rs_d = id_rs_data_i;
            m.rt_d  = id_rt_data_i; m.imm  = id_imm_i;
        end
    endtask

    task automatic drive_idle();
        id_valid_i = 0; id_rs_i = 0; id_rt_i = 0; id_rt_used_i = 0; id_write_reg_i = 0;
        id_rs_data_i = 0; id_rt_data_i = 0; id_imm_i = 0; id_alu_op_i = 0; id_shamt_i = 0;
        id_alu_src_i = 0; id_ctrl_i = 0; stall_i = 0; flush_i = 0;
        exm_reg_write_i = 0; exm_write_reg_i = 0; exm_data_i = 0;
        mwb_reg_write_i = 0; mwb_write_reg_i = 0; mwb_data_i = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        #1;
        n_tests++;
        if (observed() !== out_t'(0)) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", observed());
        end
        n_tests++;
        if (hazard_stall_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_hazard: got %b expected 0", hazard_stall_o);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stream();
        pulse_reset();
        id_valid_i = 1; id_rs_i = 3; id_rs_data_i = 32'h77; id_ctrl_i = 4'b1000; id_write_reg_i = 4;
        @(negedge clk);
        drive_idle();
        #1;
        n_tests++;
        if (ex_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_pre_valid: got %b expected 1", ex_valid_o);
        end
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if ({ex_valid_o, ex_ctrl_o, alu_a_o} !== 37'd0) begin
            n_fail++; $display("FAIL mid_reset_clear: got valid=%b ctrl=%h a=%h expected all 0",
                               ex_valid_o, ex_ctrl_o, alu_a_o);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_exm_forward();
        pulse_reset();
        id_valid_i = 1; id_rs_i = 8; id_rs_data_i = 32'hAAAA; id_ctrl_i = 4'b1000; id_write_reg_i = 2;
        id_alu_op_i = mips_pkg::ALU_ADD;
        @(negedge clk);
        drive_idle();
        exm_reg_write_i = 1; exm_write_reg_i = 8; exm_data_i = 32'h10;
        mwb_reg_write_i = 1; mwb_write_reg_i = 8; mwb_data_i = 32'h55;
        #1;
        n_tests++;
        if (alu_a_o !== (FWD ? 32'h10 : 32'hAAAA)) begin
            n_fail++; $display("FAIL exm_priority: got %h expected %h", alu_a_o, FWD ? 32'h10 : 32'hAAAA);
        end
        exm_reg_write_i = 0;
        #1;
        n_tests++;
        if (alu_a_o !== (FWD ? 32'h55 : 32'hAAAA)) begin
            n_fail++; $display("FAIL mwb_forward: got %h expected %h", alu_a_o, FWD ? 32'h55 : 32'hAAAA);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_guard();
        pulse_reset();
        id_valid_i = 1; id_rs_i = 0; id_rs_data_i = 0; id_ctrl_i = 4'b1000; id_write_reg_i = 3;
        @(negedge clk);
        drive_idle();
        exm_reg_write_i = 1; exm_write_reg_i = 0; exm_data_i = 32'hFFFF_FFFF;
        mwb_reg_write_i = 1; mwb_write_reg_i = 0; mwb_data_i = 32'hFFFF_FFFF;
        #1;
        n_tests++;
        if (alu_a_o !== 32'd0) begin
            n_fail++; $display("FAIL zero_guard: got %h expected 0", alu_a_o);
        end
        @(negedge clk);
    endtask

    task automatic lu_schedule(input int k);
        exm_reg_write_i = (k == 1); exm_write_reg_i = (k == 1) ? 5'd9 : 5'd0; exm_data_i = 32'hBAD;
        mwb_reg_write_i = (k == 2); mwb_write_reg_i = 5'd9;                  mwb_data_i = 32'h1234;
    endtask

    task automatic test_load_use();
        int  k;
        int  stalls;
        bit  done;
        pulse_reset();
        id_valid_i = 1; id_rs_i = 2; id_write_reg_i = 9; id_ctrl_i = 4'b1101;
        id_alu_src_i = 1; id_imm_i = 4; id_alu_op_i = mips_pkg::ALU_ADD;
        @(negedge clk);
        k = 0; stalls = 0; done = 0;
        while (!done && k < 8) begin
            drive_idle();
            id_valid_i = 1; id_rs_i = 1; id_rt_i = 9; id_rt_used_i = 1; id_write_reg_i = 10;
            id_ctrl_i = 4'b1000; id_rs_data_i = 1; id_alu_op_i = mips_pkg::ALU_ADD;
            id_rt_data_i = (k < 3) ? 32'hDEAD : 32'h1234;
            lu_schedule(k);
            #1;
            if (k == 0) begin
                n_tests++;
                if (hazard_stall_o !== 1'b1) begin
                    n_fail++; $display("FAIL load_use_detect: got %b expected 1", hazard_stall_o);
                end
            end
            if (k == 1) begin
                n_tests++;
                if (ex_valid_o !== 1'b0) begin
                    n_fail++; $display("FAIL load_use_bubble: got %b expected 0", ex_valid_o);
                end
            end
            if (hazard_stall_o === 1'b1) stalls++; else done = 1;
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (!done || stalls != (FWD ? 1 : 3)) begin
            n_fail++; $display("FAIL load_use_stall_count: got %0d expected %0d", stalls, FWD ? 1 : 3);
        end
        drive_idle();
        lu_schedule(k);
        #1;
        n_tests++;
        if ({ex_valid_o, alu_b_o} !== {1'b1, 32'h1234}) begin
            n_fail++; $display("FAIL load_use_operand: got valid=%b b=%h expected valid=1 b=00001234",
                               ex_valid_o, alu_b_o);
        end
        @(negedge clk);
    endtask

    task automatic test_flush_stall();
        pulse_reset();
        id_valid_i = 1; id_write_reg_i = 4; id_ctrl_i = 4'b1000; id_rs_i = 1;
        @(negedge clk);
        id_valid_i = 1; id_rs_i = 6; id_write_reg_i = 7; id_ctrl_i = 4'b1101;
        flush_i = 1; stall_i = 1;
        #1;
        n_tests++;
        if (ex_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_pre_valid: got %b expected 1", ex_valid_o);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_tests++;
        if ({ex_valid_o, ex_ctrl_o} !== 5'd0) begin
            n_fail++; $display("FAIL flush_over_stall: got valid=%b ctrl=%h expected 0", ex_valid_o, ex_ctrl_o);
        end
        @(negedge clk);
    endtask

    task automatic test_stall_hold();
        out_t exp;
        pulse_reset();
        id_valid_i = 1; id_rs_i = 1; id_rs_data_i = 32'h1111; id_rt_i = 2; id_rt_data_i = 32'h2222;
        id_write_reg_i = 5; id_ctrl_i = 4'b1000; id_alu_op_i = mips_pkg::ALU_LUI; id_shamt_i = 7;
        id_alu_src_i = 1; id_imm_i = 32'h0000_ABCD;
        exp = {1'b1, 4'b1000, 5'd5, 4'b0000, 5'd7, 32'h1111, 32'h0000_ABCD, 32'h2222};
        @(negedge clk);
        drive_idle();
        #1;
        n_tests++;
        if (alu_b_o !== 32'h0000_ABCD) begin
            n_fail++; $display("FAIL imm_path: got %h expected 0000abcd", alu_b_o);
        end
        for (int c = 0; c < 4; c++) begin
            id_valid_i = 1; id_rs_i = 5'($urandom_range(1, 31)); id_rt_i = 5'($urandom);
            id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = $urandom;
            id_alu_op_i = 4'($urandom); id_ctrl_i = 4'($urandom); id_write_reg_i = 5'($urandom);
            stall_i = 1;
            #1;
            n_tests++;
            if (observed() !== exp) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %h expected %h", c, observed(), exp);
            end
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic test_random(input int n);
        logic hz;
        pulse_reset();
        m = '0;
        for (int c = 0; c < n; c++) begin
            id_valid_i   = ($urandom_range(0, 3) != 0);
            id_rs_i      = 5'($urandom_range(0, 3));
            id_rt_i      = 5'($urandom_range(0, 3));
            id_rt_used_i = 1'($urandom);
            id_write_reg_i = 5'($urandom_range(0, 3));
            id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = $urandom;
            id_alu_op_i  = 4'($urandom_range(0, 7));
            id_shamt_i   = 5'($urandom);
            id_alu_src_i = 1'($urandom);
            id_ctrl_i    = 4'($urandom);
            flush_i      = ($urandom_range(0, 7) == 0);
            stall_i      = ($urandom_range(0, 5) == 0);
            exm_reg_write_i = 1'($urandom); exm_write_reg_i = 5'($urandom_range(0, 3)); exm_data_i = $urandom;
            mwb_reg_write_i = 1'($urandom); mwb_write_reg_i = 5'($urandom_range(0, 3)); mwb_data_i = $urandom;
            #1;
            hz = exp_hazard();
            n_tests++;
            if (hazard_stall_o !== hz) begin
                n_fail++; $display("FAIL rand_hazard[%0d]: got %b expected %b", c, hazard_stall_o, hz);
            end
            n_tests++;
            if (observed() !== exp_out()) begin
                n_fail++; $display("FAIL rand_outputs[%0d]: got %h expected %h", c, observed(), exp_out());
            end
            model_edge(hz);
            @(negedge clk);
        end
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reset_mid_stream();
        test_exm_forward();
        test_zero_guard();
        test_load_use();
        test_flush_stall();
        test_stall_hold();
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage MIPS core.
- Captures decoded fields and register-file reads from ID, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and presents final operands to the ALU.
- Detects load-use hazards and inserts bubbles.
- Sits directly upstream of the ALU (drives its operation, A, B and shift-amount inputs).

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- ALUOP_W, 4, ALU operation code width

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid_i  in  1  ID stage holds a real instruction
- id_rs_i  in  REG_AW  source register rs
- id_rt_i  in  REG_AW  source register rt
- id_rt_used_i  in  1  instruction reads rt (R-type, store, branch)
- id_write_reg_i  in  REG_AW  destination register (already rd/rt selected)
- id_rs_data_i  in  DATA_W  register-file rs read
- id_rt_data_i  in  DATA_W  register-file rt read
- id_imm_i  in  DATA_W  extended immediate
- id_alu_op_i  in  ALUOP_W  ALU operation code
- id_shamt_i  in  5  shift amount
- id_alu_src_i  in  1  1 = B takes immediate
- id_ctrl_i  in  4  {reg_write, mem_read, mem_write, mem_to_reg}
- stall_i  in  1  global freeze (memory wait)
- flush_i  in  1  branch/jump flush of ID→EX
- exm_reg_write_i, exm_write_reg_i, exm_data_i  in  1/REG_AW/DATA_W  EX/MEM writeback info
- mwb_reg_write_i, mwb_write_reg_i, mwb_data_i  in  1/REG_AW/DATA_W  MEM/WB writeback info
- hazard_stall_o  out  1  hold PC and IF/ID (load-use)
- ex_valid_o  out  1  EX stage holds a real instruction
- alu_operation_o  out  ALUOP_W  to ALU
- alu_a_o, alu_b_o  out  DATA_W  final operands to ALU
- alu_shamt_o  out  5  to ALU
- ex_store_data_o  out  DATA_W  forwarded rt for stores
- ex_write_reg_o  out  REG_AW  destination register
- ex_ctrl_o  out  4  registered control bits

Behaviour:
- Reset (async, reset=0): all registered fields cleared to 0; ex_valid_o=0, ex_ctrl_o=0. Combinational outputs follow the cleared registers.
- Update priority each rising edge:
  - flush_i: load bubble.
  - else stall_i: hold all registers.
  - else hazard_stall_o: load bubble.
  - else: load ID fields, with ex_valid = id_valid_i.
- Bubble: valid, ctrl, write_reg, alu_op cleared to 0; data fields cleared to 0.
- hazard_stall_o (combinational) = ex_valid & ex_ctrl.mem_read & ex_write_reg≠0 & id_valid_i & (ex_write_reg==id_rs_i | (id_rt_used_i & ex_write_reg==id_rt_i)).
  - Asserted exactly one cycle per load-use pair, unless stall_i also holds the pipe.
- Forwarding (combinational, per source, separately for rs and rt):
  - EX/MEM match (reg_write & write_reg≠0 & equal) has priority over MEM/WB match.
  - Otherwise use the registered register-file value.
  - $0 is never forwarded.
- alu_b_o = alu_src ? registered imm : forwarded rt.
- ex_store_data_o = forwarded rt, always.
- Latency: ID inputs appear on outputs 1 cycle later. Forwarding adds 0 cycles.
- Simultaneous flush_i and stall_i: flush wins.
- Reset mid-stall: stage is cleared immediately, with no held state.

Optional Feature:
- Macro: OPERAND_FORWARDING_EN.
- Defined: forwarding exactly as described above.
- Undefined:
  - Operands come straight from the registered register-file values.
  - hazard_stall_o also asserts for any ID source matching a valid, writing, nonzero destination in EX, EX/MEM or MEM/WB (register file does not bypass).
  - One bubble is inserted per stalled cycle.

Decomposition:
- Shared package mips_pkg:
  - ALU op localparams ADD=4'b0011, SUB=4'b0101, LUI=4'b0000, OR=4'b0001, SLL=4'b0010, SRL=4'b0100, AND=4'b0110, NOR=4'b0111.
  - ctrl bit indices.
  - Forward-select encoding FWD_RF=2'd0, FWD_MWB=2'd1, FWD_EXM=2'd2.
- One sub-module, operand_forward_sel: source-match plus 3:1 mux; instantiated twice (rs, rt).

Test Plan:
- Reset mid-stream: reset=0 while ex_valid_o=1 → same cycle ex_valid_o=0, ex_ctrl_o=0, alu_a_o=0.
- EX/MEM forward: EX write_reg=$8, exm_data=0x0000_0010, mwb also writes $8=0x55, ID rs=$8 → next cycle alu_a_o=0x10.
- $0 guard: exm_write_reg=0, reg_write=1, exm_data=0xFFFF_FFFF, ID rs=$0, rs_data=0 → alu_a_o=0.
- Load-use: lw into $9 in EX, ID add using rt=$9 →
  - hazard_stall_o=1 for one cycle; next cycle ex_valid_o=0.
  - Following cycle the add enters with alu_b_o=mwb_data (0x1234).
- flush_i and stall_i together with a valid ID → next cycle ex_valid_o=0, ex_ctrl_o=0.
- stall_i alone for 3 cycles → all outputs held bit-identical; ALU-immediate path (alu_src=1, imm=0x0000_ABCD, op LUI) passes alu_b_o=0x0000_ABCD.
